// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Fills instruction memory from a valid/ready word stream before the CPU is
// allowed to run. While a load is pending or in progress the CPU is held in
// stall; once exactly load_len words have been written the hold is released
// and done is raised. Bad lengths (0 or > DEPTH) are rejected into an error
// state that keeps the CPU held.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse requesting a load of load_len words
//   load_len   in   word count, sampled only when a start is accepted
//   s_valid    in   source presents a word on s_data
//   s_data     in   instruction word
//   s_ready    out  loader accepts a word this cycle (only in LOAD)
//   mem_we     out  instruction memory write enable (registered)
//   mem_addr   out  byte address of the write (word index << 2)
//   mem_wdata  out  word being written
//   cpu_hold   out  1 keeps the CPU PC at 0 / stalled
//   done       out  image fully loaded, CPU running
//   error      out  most recent start was rejected for a bad length
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int DEPTH = 100,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             cpu_hold_q;
  logic             done_q;
  logic             error_q;

  logic len_ok;
  logic xfer;

  // Accepting load_len == DEPTH is fine: LEN_W is wide enough to hold DEPTH,
  // and the last word lands at (DEPTH-1)*4, so no address wrap is possible.
  assign len_ok = (load_len != '0) && (load_len <= DEPTH_L);

  // Ready is a pure decode of the registered state, so the source never
  // sees a combinational path from its own valid.
  assign s_ready = (state_q == LOAD);
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted word.
      mem_we_q <= 1'b0;

      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            if (len_ok) begin
              state_q <= LOAD;
              len_q   <= load_len;
              count_q <= '0;
              error_q <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end

        LOAD: begin
          // start is deliberately ignored here; only the stream advances.
          if (xfer) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= s_data;
            mem_addr_q  <= 32'({count_q, 2'b00});
            count_q     <= count_q + ONE_L;
            // Final word: hold release lands on the same edge as the last
            // write. The CPU fetches address 0 first, which is long written.
            if (count_q == len_q - ONE_L) begin
              state_q    <= DONE;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          cpu_hold_q <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int DEPTH = 100;
  localparam int LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] load_len;
  logic             s_valid;
  logic [31:0]      s_data;
  logic             s_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_hold;
  logic             done;
  logic             error;

  imem_boot_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  err_cnt = 0;
  int  chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  // Every write seen on the memory port must match the oldest expected one.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_we", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("wr_addr", mem_addr, mon_e.addr);
        check_val("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start    = 1'b1;
    load_len = LEN_W'(len);
    tick();
    start    = 1'b0;
  endtask

  // One handshake; the bench knows the address the word must land at.
  task automatic xfer(input logic [31:0] data, input logic [31:0] addr);
    wr_t e;
    check_val("s_ready_in_load", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = data;
    e.addr  = addr;
    e.data  = data;
    sb_q.push_back(e);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic bubble();
    s_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    tick();
  endtask

  task automatic check_status(input string tag, input logic hold, input logic dn,
                              input logic er, input logic rdy);
    check_val({tag, "_hold"},  32'(cpu_hold), 32'(hold));
    check_val({tag, "_done"},  32'(done),     32'(dn));
    check_val({tag, "_error"}, 32'(error),    32'(er));
    check_val({tag, "_ready"}, 32'(s_ready),  32'(rdy));
  endtask

  logic [31:0] prog [4];

  initial begin
    rst = 1'b1; start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
    prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020; prog[3] = 32'hAC0A_0000;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("reset_we",    32'(mem_we), 32'd0);
    check_val("reset_addr",  mem_addr,    32'd0);
    check_val("reset_wdata", mem_wdata,   32'd0);

    // Basic back-to-back load of 4 words
    do_start(4);
    check_status("basic_load", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check_val("basic_not_done", 32'(done), 32'd0);
      xfer(prog[i], 32'(i * 4));
    end
    check_status("basic_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("basic_last_we", 32'(mem_we), 32'd1);

    // Bubbles: valid pattern 1,0,0,1,0,1
    do_start(3);
    check_status("bub_load", 1'b1, 1'b0, 1'b0, 1'b1);
    xfer(32'h1111_0000, 32'h0);
    bubble(); bubble();
    check_val("bub_gap_we", 32'(mem_we), 32'd0);
    xfer(32'h1111_0001, 32'h4);
    bubble();
    check_val("bub_not_done", 32'(done), 32'd0);
    xfer(32'h1111_0002, 32'h8);
    check_status("bub_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Length errors
    do_start(0);
    check_status("len0", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("len0_we", 32'(mem_we), 32'd0);
    do_start(DEPTH + 1);
    check_status("len101", 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("len101_we", 32'(mem_we), 32'd0);
    do_start(DEPTH);
    check_status("len100", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) xfer(32'hA500_0000 + 32'(i), 32'(i * 4));
    check_val("len100_last_addr", mem_addr, 32'h18C);
    check_status("len100_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-load
    do_start(8);
    for (int i = 0; i < 3; i++) xfer(32'hB000_0000 + 32'(i), 32'(i * 4));
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hBAD0_0003;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    check_status("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("midrst_we", 32'(mem_we), 32'd0);
    do_start(2);
    xfer(32'hC000_0000, 32'h0);
    xfer(32'hC000_0001, 32'h4);
    check_status("midrst_reload", 1'b0, 1'b1, 1'b0, 1'b0);

    // Start ignored during LOAD, then reload from DONE
    do_start(3);
    xfer(32'hD000_0000, 32'h0);
    start = 1'b1; load_len = LEN_W'(1);
    xfer(32'hD000_0001, 32'h4);
    start = 1'b0;
    check_status("ign_start", 1'b1, 1'b0, 1'b0, 1'b1);
    xfer(32'hD000_0002, 32'h8);
    check_status("ign_done", 1'b0, 1'b1, 1'b0, 1'b0);
    do_start(1);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b1);
    xfer(32'hE000_0000, 32'h0);
    check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // rst together with start
    rst = 1'b1; start = 1'b1; load_len = LEN_W'(2);
    tick();
    rst = 1'b0; start = 1'b0;
    check_status("rst_start", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_start_addr", mem_addr, 32'd0);

    // rst together with the final handshake
    do_start(2);
    xfer(32'hF000_0000, 32'h0);
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hF000_0001;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    check_status("rst_last", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_last_we", 32'(mem_we), 32'd0);
    tick(); tick();

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
